// File: rtl/shreg_var_insert_sync_rst_if.sv
// Sample/control bundle for the variable-length delay line.
// The producer (testbench or upstream) holds the master side; the delay line is the slave.
interface shreg_var_insert_sync_rst_if #(
    parameter int unsigned width = 1,
    parameter int unsigned lw    = 32
);
    logic             e;
    logic [width-1:0] i;
    logic             i_valid;
    logic [lw-1:0]    l;
    logic [width-1:0] q;
    logic             q_valid;
    logic             l_err;

    modport master (
        output e,
        output i,
        output i_valid,
        output l,
        input  q,
        input  q_valid,
        input  l_err
    );

    modport slave (
        input  e,
        input  i,
        input  i_valid,
        input  l,
        output q,
        output q_valid,
        output l_err
    );
endinterface

// File: rtl/shreg_var_insert_sync_rst.sv
// Variable-length delay line: samples are inserted at stage l and read from stage 0,
// giving an i->q delay of l+1 enabled edges. A valid bit travels with every stage.
module shreg_var_insert_sync_rst #(
    parameter int unsigned width = 1,
    parameter int unsigned depth = 130,
    parameter int unsigned lw    = 32
) (
    input  logic                      clk,
    input  logic                      r,
    shreg_var_insert_sync_rst_if.slave bus
);
    localparam int unsigned IW = (depth > 1) ? $clog2(depth) : 1;
    // Compare width large enough for both the full l port and the depth constant.
    localparam int unsigned CW = (lw > IW + 1) ? lw : IW + 1;

    logic [depth-1:0][width-1:0] data_q;
    logic [depth-1:0][width-1:0] data_d;
    logic [depth-1:0][width-1:0] data_shift_c;
    logic [depth-1:0]            vld_q;
    logic [depth-1:0]            vld_d;
    logic [depth-1:0]            vld_shift_c;
    logic                        l_err_q;
    logic                        l_err_d;
    logic                        l_over_c;
    logic [IW-1:0]               le_c;

    // Out-of-range lengths clamp to the deepest stage; the compare sees all lw bits.
    assign l_over_c = (CW'(bus.l) >= CW'(depth));
    assign le_c     = l_over_c ? IW'(depth - 1) : IW'(bus.l);

    // Whole chain moves one stage toward 0; zeros enter at the top.
    assign data_shift_c = {width'(0), data_q[depth-1:1]};
    assign vld_shift_c  = {1'b0, vld_q[depth-1:1]};

    always_comb begin
        data_d  = data_q;
        vld_d   = vld_q;
        l_err_d = l_err_q;
        for (int d = 0; d < int'(depth); d++) begin
            if (IW'(d) == le_c) begin
                data_d[d] = bus.i;
                vld_d[d]  = bus.i_valid;
            end else begin
                data_d[d] = data_shift_c[d];
                vld_d[d]  = vld_shift_c[d];
            end
        end
        l_err_d = l_err_q | l_over_c;
    end

    // Reset wins over enable; with e low everything, including l_err, holds.
    always_ff @(posedge clk) begin
        if (r) begin
            data_q  <= '0;
            vld_q   <= '0;
            l_err_q <= 1'b0;
        end else if (bus.e) begin
            data_q  <= data_d;
            vld_q   <= vld_d;
            l_err_q <= l_err_d;
        end
    end

    assign bus.q       = data_q[0];
    assign bus.q_valid = vld_q[0];
    assign bus.l_err   = l_err_q;
endmodule

// File: tb/tb_shreg_var_insert_sync_rst.sv
// Directed bench for the variable-length delay line; expected values are hand-derived
// from the l+1 latency rule and the insert/shift behaviour of each stage.
module tb_shreg_var_insert_sync_rst;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 130;
    localparam int unsigned LW    = 32;

    logic clk = 1'b0;
    logic r;
    int   tests_run    = 0;
    int   tests_failed = 0;

    shreg_var_insert_sync_rst_if #(.width(WIDTH), .lw(LW)) bus ();

    shreg_var_insert_sync_rst #(
        .width(WIDTH),
        .depth(DEPTH),
        .lw   (LW)
    ) dut (
        .clk(clk),
        .r  (r),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock edge; outputs are stable 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        r           = 1'b1;
        bus.e       = 1'b0;
        bus.i       = '0;
        bus.i_valid = 1'b0;
        bus.l       = '0;
        step();
        r = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [31:0] len, input logic [7:0] din,
                         input logic dv);
        bus.e       = en;
        bus.l       = len;
        bus.i       = din;
        bus.i_valid = dv;
    endtask

    initial begin
        int exp_q;
        int hits;

        // 1: reset state, then l=0 gives one-cycle latency
        r = 1'b0;
        drive(1'b0, 32'd0, 8'd0, 1'b0);
        reset_dut();
        check("t1_rst_q", 32'(bus.q), 32'd0);
        check("t1_rst_qv", 32'(bus.q_valid), 32'd0);
        check("t1_rst_err", 32'(bus.l_err), 32'd0);
        drive(1'b1, 32'd0, 8'd1, 1'b1); step();
        check("t1_s0_q", 32'(bus.q), 32'd1);
        check("t1_s0_qv", 32'(bus.q_valid), 32'd1);
        drive(1'b1, 32'd0, 8'd0, 1'b1); step();
        check("t1_s1_q", 32'(bus.q), 32'd0);
        check("t1_s1_qv", 32'(bus.q_valid), 32'd1);
        drive(1'b1, 32'd0, 8'd1, 1'b1); step();
        check("t1_s2_q", 32'(bus.q), 32'd1);
        check("t1_s2_qv", 32'(bus.q_valid), 32'd1);

        // 2: maximum length, single pulse surfaces after edge 130 only
        reset_dut();
        drive(1'b1, 32'd129, 8'd1, 1'b1); step();
        check("t2_e1_qv", 32'(bus.q_valid), 32'd0);
        drive(1'b1, 32'd129, 8'd0, 1'b0);
        hits = 0;
        for (int n = 2; n <= 129; n++) begin
            step();
            if (bus.q_valid !== 1'b0) hits++;
        end
        check("t2_early_valid_cycles", 32'(hits), 32'd0);
        step();
        check("t2_e130_q", 32'(bus.q), 32'd1);
        check("t2_e130_qv", 32'(bus.q_valid), 32'd1);
        step();
        check("t2_e131_qv", 32'(bus.q_valid), 32'd0);
        check("t2_err", 32'(bus.l_err), 32'd0);

        // 3: l=5 stream with a 3-cycle enable gap (l changed during gap is ignored)
        reset_dut();
        begin
            int n;
            n = 0;
            for (int k = 1; k <= 14; k++) begin
                if (k >= 5 && k <= 7) begin
                    drive(1'b0, 32'd0, 8'hFF, 1'b1);
                end else begin
                    n++;
                    drive(1'b1, 32'd5, 8'(10 + n), 1'b1);
                end
                step();
                if (n >= 6) begin
                    check($sformatf("t3_k%0d_qv", k), 32'(bus.q_valid), 32'd1);
                    check($sformatf("t3_k%0d_q", k), 32'(bus.q), 32'(10 + n - 5));
                end else begin
                    check($sformatf("t3_k%0d_qv", k), 32'(bus.q_valid), 32'd0);
                end
            end
        end

        // 4: l=4 -> 7 gives a 3-cycle gap; l=7 -> 2 drops samples 16..20
        reset_dut();
        for (int n = 1; n <= 28; n++) begin
            int len;
            len = (n <= 8) ? 4 : ((n <= 20) ? 7 : 2);
            drive(1'b1, 32'(len), 8'(n), 1'b1);
            step();
            if (n < 5)       exp_q = -1;
            else if (n <= 12) exp_q = n - 4;
            else if (n <= 15) exp_q = -1;
            else if (n <= 20) exp_q = n - 7;
            else if (n == 21) exp_q = 14;
            else if (n == 22) exp_q = 15;
            else              exp_q = n - 2;
            if (exp_q < 0) begin
                check($sformatf("t4_n%0d_qv", n), 32'(bus.q_valid), 32'd0);
            end else begin
                check($sformatf("t4_n%0d_qv", n), 32'(bus.q_valid), 32'd1);
                check($sformatf("t4_n%0d_q", n), 32'(bus.q), 32'(exp_q));
            end
        end

        // 5: out-of-range length clamps to 129 and sets sticky l_err
        reset_dut();
        drive(1'b0, 32'd200, 8'h00, 1'b0); step();
        check("t5_dis_err", 32'(bus.l_err), 32'd0);
        drive(1'b1, 32'd200, 8'h5A, 1'b1); step();
        check("t5_e1_err", 32'(bus.l_err), 32'd1);
        check("t5_e1_qv", 32'(bus.q_valid), 32'd0);
        drive(1'b1, 32'd200, 8'h00, 1'b0);
        for (int n = 2; n <= 129; n++) step();
        check("t5_e129_qv", 32'(bus.q_valid), 32'd0);
        step();
        check("t5_e130_q", 32'(bus.q), 32'h5A);
        check("t5_e130_qv", 32'(bus.q_valid), 32'd1);
        check("t5_e130_err", 32'(bus.l_err), 32'd1);
        drive(1'b1, 32'd0, 8'h00, 1'b0); step();
        check("t5_sticky_err", 32'(bus.l_err), 32'd1);
        r = 1'b1; step(); r = 1'b0;
        check("t5_rst_err", 32'(bus.l_err), 32'd0);
        check("t5_rst_qv", 32'(bus.q_valid), 32'd0);
        drive(1'b1, 32'd129, 8'h00, 1'b0); step();
        check("t5_l129_err", 32'(bus.l_err), 32'd0);
        drive(1'b1, 32'd130, 8'h00, 1'b0); step();
        check("t5_l130_err", 32'(bus.l_err), 32'd1);
        reset_dut();
        drive(1'b1, 32'd256, 8'h77, 1'b1); step();
        check("t5_l256_qv", 32'(bus.q_valid), 32'd0);
        check("t5_l256_err", 32'(bus.l_err), 32'd1);

        // 6: reset mid-stream with e=1 discards everything in flight
        reset_dut();
        for (int k = 1; k <= 15; k++) begin
            drive(1'b1, 32'd10, 8'(k), 1'b1);
            step();
        end
        check("t6_pre_q", 32'(bus.q), 32'd5);
        check("t6_pre_qv", 32'(bus.q_valid), 32'd1);
        r = 1'b1;
        drive(1'b1, 32'd10, 8'hEE, 1'b1);
        step();
        r = 1'b0;
        check("t6_rst_q", 32'(bus.q), 32'd0);
        check("t6_rst_qv", 32'(bus.q_valid), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            drive(1'b1, 32'd10, 8'(8'h40 + k), 1'b1);
            step();
            if (k <= 10) begin
                check($sformatf("t6_k%0d_q", k), 32'(bus.q), 32'd0);
                check($sformatf("t6_k%0d_qv", k), 32'(bus.q_valid), 32'd0);
            end else begin
                check("t6_first_q", 32'(bus.q), 32'h41);
                check("t6_first_qv", 32'(bus.q_valid), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
